// File: rtl/mdu_if.sv
// mdu_if: request/result bundle between the EX stage and the HI/LO sequencer.
// The master side drives the request and flush; the slave side returns stall, busy and the HI/LO write.
interface mdu_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        hilo_we;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        div_zero;

    modport master (
        output start, op, a, b, flush,
        input  stall, busy, hilo_we, hi_out, lo_out, div_zero
    );

    modport slave (
        input  start, op, a, b, flush,
        output stall, busy, hilo_we, hi_out, lo_out, div_zero
    );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer issuing one HI/LO write per operation.
// Define MDU_DIV_EN to build the restoring divider; without it DIV/DIVU report a reserved instruction.
module mdu_ctrl #(
    parameter int MUL_LAT = 1
) (
    input logic   clk,
    input logic   rst,
    mdu_if.slave  mdu
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state_r;
    state_t      next_s;
    logic [4:0]  cnt_r;
    logic [31:0] ma_r;
    logic [31:0] mb_r;
    logic        msgn_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        dz_r;
    logic        we_en_r;
    logic        stall_s;
    logic        busy_s;
    logic        hilo_we_s;
    logic        div_zero_s;
    logic [63:0] ext_a_s;
    logic [63:0] ext_b_s;
    logic [63:0] product_s;
    logic [63:0] mul_res_s;

    // Sign-extending both operands lets one 64-bit multiply serve MULT and MULTU.
    assign ext_a_s   = {{32{msgn_r & ma_r[31]}}, ma_r};
    assign ext_b_s   = {{32{msgn_r & mb_r[31]}}, mb_r};
    assign product_s = ext_a_s * ext_b_s;

    generate
        if (MUL_LAT == 1) begin : g_lat1
            assign mul_res_s = product_s;
        end else begin : g_pipe
            logic [63:0] pipe_r [0:MUL_LAT-2];
            // Product stages ahead of the HI/LO registers, which act as the last stage.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < MUL_LAT - 1; i++) begin
                        pipe_r[i] <= 64'd0;
                    end
                end else if (state_r == MUL) begin
                    pipe_r[0] <= product_s;
                    for (int i = 1; i < MUL_LAT - 1; i++) begin
                        pipe_r[i] <= pipe_r[i-1];
                    end
                end
            end
            assign mul_res_s = pipe_r[MUL_LAT-2];
        end
    endgenerate

`ifdef MDU_DIV_EN
    logic [31:0] dvs_r;
    logic [31:0] quo_r;
    logic [31:0] rem_r;
    logic        neg_q_r;
    logic        neg_r_r;
    logic [32:0] shl_s;
    logic        ge_s;
    logic [31:0] sub_s;

    function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

    // 33-bit partial remainder; the true difference is below the divisor, so 32 bits of it suffice.
    assign shl_s = {rem_r, quo_r[31]};
    assign ge_s  = (shl_s >= {1'b0, dvs_r});
    assign sub_s = shl_s[31:0] - dvs_r;

    // Restoring divider: magnitudes loaded on accept, one quotient bit per DIV cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvs_r   <= 32'd0;
            quo_r   <= 32'd0;
            rem_r   <= 32'd0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if ((state_r == IDLE) && mdu.start && !mdu.flush && mdu.op[1]) begin
            dvs_r   <= mag(mdu.b, ~mdu.op[0]);
            quo_r   <= mag(mdu.a, ~mdu.op[0]);
            rem_r   <= 32'd0;
            neg_q_r <= ~mdu.op[0] & (mdu.a[31] ^ mdu.b[31]);
            neg_r_r <= ~mdu.op[0] & mdu.a[31];
        end else if (state_r == DIV) begin
            rem_r <= ge_s ? sub_s : shl_s[31:0];
            quo_r <= {quo_r[30:0], ge_s};
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state selection; flush overrides every state.
    always_comb begin
        next_s = state_r;
        if (mdu.flush) begin
            next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (mdu.start) begin
                        if (!mdu.op[1]) begin
                            next_s = MUL;
`ifdef MDU_DIV_EN
                        end else if (mdu.b == 32'd0) begin
                            next_s = DONE;
                        end else begin
                            next_s = DIV;
                        end
`else
                        end else begin
                            next_s = DONE;
                        end
`endif
                    end else begin
                        next_s = IDLE;
                    end
                end
                MUL:     next_s = (cnt_r == 5'd0) ? DONE : MUL;
`ifdef MDU_DIV_EN
                DIV:     next_s = (cnt_r == 5'd31) ? FIX : DIV;
                FIX:     next_s = DONE;
`endif
                DONE:    next_s = IDLE;
                default: next_s = IDLE;
            endcase
        end
    end

    // Outputs decoded from state; flush suppresses the write strobe in the same cycle.
    always_comb begin
        stall_s    = 1'b0;
        hilo_we_s  = 1'b0;
        div_zero_s = 1'b0;
        busy_s     = (state_r != IDLE);
        case (state_r)
            IDLE:          stall_s = mdu.start & ~mdu.flush;
            MUL, DIV, FIX: stall_s = 1'b1;
            DONE: begin
                hilo_we_s  = we_en_r & ~mdu.flush;
                div_zero_s = dz_r & ~mdu.flush;
            end
            default:       stall_s = 1'b0;
        endcase
    end

    // Counter, latched multiply operands and the HI/LO result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= 5'd0;
            ma_r    <= 32'd0;
            mb_r    <= 32'd0;
            msgn_r  <= 1'b0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            dz_r    <= 1'b0;
            we_en_r <= 1'b0;
        end else if (mdu.flush) begin
            cnt_r <= 5'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (mdu.start) begin
                        if (!mdu.op[1]) begin
                            ma_r    <= mdu.a;
                            mb_r    <= mdu.b;
                            msgn_r  <= ~mdu.op[0];
                            cnt_r   <= 5'(MUL_LAT - 1);
                            dz_r    <= 1'b0;
                            we_en_r <= 1'b1;
                        end else begin
                            cnt_r <= 5'd0;
`ifdef MDU_DIV_EN
                            we_en_r <= 1'b1;
                            dz_r    <= (mdu.b == 32'd0);
                            if (mdu.b == 32'd0) begin
                                hi_r <= mdu.a;
                                lo_r <= 32'hFFFF_FFFF;
                            end
`else
                            // Reserved instruction: flag it, leave HI/LO untouched.
                            we_en_r <= 1'b0;
                            dz_r    <= 1'b1;
`endif
                        end
                    end
                end
                MUL: begin
                    if (cnt_r == 5'd0) begin
                        {hi_r, lo_r} <= mul_res_s;
                    end else begin
                        cnt_r <= cnt_r - 5'd1;
                    end
                end
`ifdef MDU_DIV_EN
                DIV: cnt_r <= cnt_r + 5'd1;
                FIX: begin
                    lo_r <= neg_q_r ? (32'd0 - quo_r) : quo_r;
                    hi_r <= neg_r_r ? (32'd0 - rem_r) : rem_r;
                end
`endif
                default: cnt_r <= 5'd0;
            endcase
        end
    end

    assign mdu.stall    = stall_s;
    assign mdu.busy     = busy_s;
    assign mdu.hilo_we  = hilo_we_s;
    assign mdu.div_zero = div_zero_s;
    assign mdu.hi_out   = hi_r;
    assign mdu.lo_out   = lo_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed vectors for mdu_ctrl with a scoreboard of expected HI/LO writes.
// Expectations follow whether MDU_DIV_EN is defined for the build.
module tb_mdu_ctrl;
    localparam int LAT = 1;

    typedef struct {
        int          cyc;
        logic        we;
        logic        dz;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mh = 32'd0;
    logic [31:0] ml = 32'd0;
    exp_t        sb[$];

    mdu_if mdu();

    mdu_ctrl #(.MUL_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .mdu (mdu)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (mdu.busy !== 1'b0 && k < 60) begin
            tick();
            k++;
        end
        if (mdu.busy !== 1'b0) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", mdu.busy, k);
        end
    endtask

    // Issue one operation in the current cycle (cycle 0) and expect its DONE lat cycles later.
    task automatic issue(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                         input int lat, input logic we, input logic dz,
                         input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        mdu.start = 1'b1;
        mdu.op    = o;
        mdu.a     = va;
        mdu.b     = vb;
        e.cyc = cyc + lat;
        e.we  = we;
        e.dz  = dz;
        e.hi  = eh;
        e.lo  = el;
        sb.push_back(e);
        if (we) begin
            mh = eh;
            ml = el;
        end
        @(negedge clk);
        chk("stall_cycle0", mdu.stall, 1'b1);
        tick();
        mdu.start = 1'b0;
        @(negedge clk);
        chk("stall_cycle1", mdu.stall, (lat > 1) ? 1'b1 : 1'b0);
        wait_idle();
    endtask

    task automatic div_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] eq, input logic [31:0] er);
`ifdef MDU_DIV_EN
        if (vb == 32'd0) begin
            issue(o, va, vb, 1, 1'b1, 1'b1, va, 32'hFFFF_FFFF);
        end else begin
            issue(o, va, vb, 34, 1'b1, 1'b0, er, eq);
        end
`else
        issue(o, va, vb, 1, 1'b0, 1'b1, mh, ml);
`endif
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_stall"}, mdu.stall, 1'b0);
        chk({tag, "_busy"}, mdu.busy, 1'b0);
        chk({tag, "_hilo_we"}, mdu.hilo_we, 1'b0);
        chk({tag, "_div_zero"}, mdu.div_zero, 1'b0);
        chk({tag, "_hi"}, mdu.hi_out, 32'd0);
        chk({tag, "_lo"}, mdu.lo_out, 32'd0);
    endtask

    // Monitor: every strobe the DUT presents must match the oldest expected write.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst === 1'b0 && (mdu.hilo_we === 1'b1 || mdu.div_zero === 1'b1)) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: hilo_we=%b div_zero=%b at cycle %0d, required none",
                         mdu.hilo_we, mdu.div_zero, cyc);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("hilo_we", mdu.hilo_we, e.we);
                chk("div_zero", mdu.div_zero, e.dz);
                chk("hi_out", mdu.hi_out, e.hi);
                chk("lo_out", mdu.lo_out, e.lo);
                chk("stall_in_done", mdu.stall, 1'b0);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        mdu.start = 1'b0;
        mdu.op    = 2'b00;
        mdu.a     = 32'd0;
        mdu.b     = 32'd0;
        mdu.flush = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset");
        tick();

        issue(2'b00, 32'hFFFF_FFFE, 32'd3, LAT + 1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT + 1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
        issue(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, LAT + 1, 1'b1, 1'b0, 32'hC000_0000, 32'h8000_0000);
        div_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        div_op(2'b11, 32'd7, 32'd2, 32'd3, 32'd1);
        div_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        div_op(2'b10, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        div_op(2'b11, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
        div_op(2'b11, 32'h0000_0064, 32'd0, 32'd0, 32'd0);

        // start held high through MUL and DONE with a different op: only the first is accepted
        mdu.start = 1'b1; mdu.op = 2'b00; mdu.a = 32'd5; mdu.b = 32'd6;
        sb.push_back('{cyc + LAT + 1, 1'b1, 1'b0, 32'd0, 32'd30});
        mh = 32'd0; ml = 32'd30;
        tick();
        mdu.op = 2'b11; mdu.a = 32'd1; mdu.b = 32'd0;
        repeat (LAT) tick();
        tick();
        mdu.start = 1'b0;
        @(negedge clk);
        chk("start_ignored_busy", mdu.busy, 1'b0);
        tick();

        // start together with flush in IDLE is dropped
        mdu.start = 1'b1; mdu.flush = 1'b1; mdu.op = 2'b00; mdu.a = 32'd3; mdu.b = 32'd3;
        @(negedge clk);
        chk("flush_start_stall", mdu.stall, 1'b0);
        tick();
        mdu.start = 1'b0; mdu.flush = 1'b0;
        @(negedge clk);
        chk("flush_start_busy", mdu.busy, 1'b0);
        tick();

        // flush while in MUL: no write, HI/LO keep their value
        mdu.start = 1'b1; mdu.op = 2'b00; mdu.a = 32'd9; mdu.b = 32'd9;
        tick();
        mdu.start = 1'b0; mdu.flush = 1'b1;
        @(negedge clk);
        chk("flush_mul_we", mdu.hilo_we, 1'b0);
        tick();
        mdu.flush = 1'b0;
        @(negedge clk);
        chk("flush_mul_busy", mdu.busy, 1'b0);
        chk("flush_mul_hi", mdu.hi_out, mh);
        chk("flush_mul_lo", mdu.lo_out, ml);
        tick();

        // flush in the DONE cycle gates the strobe off
        mdu.start = 1'b1; mdu.op = 2'b00; mdu.a = 32'd2; mdu.b = 32'd2;
        tick();
        mdu.start = 1'b0;
        repeat (LAT) tick();
        mdu.flush = 1'b1;
        @(negedge clk);
        chk("flush_done_we", mdu.hilo_we, 1'b0);
        chk("flush_done_dz", mdu.div_zero, 1'b0);
        tick();
        mdu.flush = 1'b0;
        @(negedge clk);
        chk("flush_done_busy", mdu.busy, 1'b0);
        tick();
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT + 1, 1'b1, 1'b0, 32'd0, 32'd1);

`ifdef MDU_DIV_EN
        // DIV flushed in cycle 10, with an ignored start pulse in cycle 5
        mdu.start = 1'b1; mdu.op = 2'b10; mdu.a = 32'd100; mdu.b = 32'd7;
        tick();
        mdu.start = 1'b0;
        repeat (4) tick();
        mdu.start = 1'b1; mdu.op = 2'b00; mdu.a = 32'd1; mdu.b = 32'd1;
        tick();
        mdu.start = 1'b0;
        repeat (4) tick();
        mdu.flush = 1'b1;
        @(negedge clk);
        chk("flush_div_we", mdu.hilo_we, 1'b0);
        tick();
        mdu.flush = 1'b0;
        @(negedge clk);
        chk("flush_div_busy", mdu.busy, 1'b0);
        chk("flush_div_stall", mdu.stall, 1'b0);
        repeat (40) tick();
        chk("flush_div_hi", mdu.hi_out, mh);
        chk("flush_div_lo", mdu.lo_out, ml);
`endif

        // rst during MUL returns everything to reset values
        mdu.start = 1'b1; mdu.op = 2'b01; mdu.a = 32'hFFFF_FFFF; mdu.b = 32'd2;
        tick();
        mdu.start = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("rst_mul");
        mh = 32'd0; ml = 32'd0;
        tick();

`ifdef MDU_DIV_EN
        issue(2'b01, 32'd3, 32'd5, LAT + 1, 1'b1, 1'b0, 32'd0, 32'd15);
        // rst at cycle 20 of a DIVU
        mdu.start = 1'b1; mdu.op = 2'b11; mdu.a = 32'hFFFF_FFFF; mdu.b = 32'd3;
        tick();
        mdu.start = 1'b0;
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("rst_div");
        repeat (40) tick();
`endif

        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
